// File: rtl/turfio_cout_pkg.sv
// Shared constants and FSM state type for the TURFIO COUT scheduler and serializer.
package turfio_cout_pkg;

  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  localparam logic [31:0] IDLE_VALUE_DFLT = 32'h0000_0000;
  localparam logic [31:0] TRAIN_VALUE     = 32'hA55A_6996;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/turfio_cout_rr_arb.sv
// Round-robin one-hot picker; the pointer register is owned by the caller.
module turfio_cout_rr_arb #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   next_ptr
);

  logic          found;
  logic [PW-1:0] idx;

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (en && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        next_ptr   = PW'((int'(idx) + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/turfio_cout_sched.sv
// COUT frame scheduler: frame-strobe lock tracking, round-robin command slot sharing, training.
// Optional per-requester statistics when TURFIO_COUT_SCHED_STATS_EN is defined.
module turfio_cout_sched
  import turfio_cout_pkg::*;
#(
  parameter int          NREQ        = 3,
  parameter logic [31:0] IDLE_VALUE  = IDLE_VALUE_DFLT,
  parameter int          LOCK_FRAMES = 4
) (
  input  logic                 if_clk_i,
  input  logic                 if_rst_i,
  input  logic                 frame_i,
  input  logic [32*NREQ-1:0]   req_tdata_i,
  input  logic [NREQ-1:0]      req_tvalid_i,
  output logic [NREQ-1:0]      req_tready_o,
  input  logic                 train_i,
`ifdef TURFIO_COUT_SCHED_STATS_EN
  input  logic                 stat_clr_i,
  output logic [16*NREQ-1:0]   stat_grants_o,
  output logic [15:0]          stat_idle_o,
`endif
  output logic [31:0]          cout_command_o,
  output logic                 cout_train_o,
  output logic                 locked_o,
  output logic                 frame_err_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t     state;
  logic [CNT_W-1:0] space_cnt;
  logic [3:0]       good_cnt;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    next_ptr;
  logic [NREQ-1:0]  grant;
  logic [31:0]      grant_word;
  logic             frame_good;
  logic             frame_bad;
  logic             arb_en;

  assign frame_good = frame_i && (space_cnt == CNT_LAST);
  // Early strobe (counter short of 7) or missing strobe (counter at 7, no strobe).
  assign frame_bad  = (frame_i && (space_cnt != CNT_LAST)) || (!frame_i && (space_cnt == CNT_LAST));
  assign arb_en     = (state == LOCKED) && frame_good && !train_i && !if_rst_i;

  turfio_cout_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .valid    (req_tvalid_i),
    .ptr      (rr_ptr),
    .en       (arb_en),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  // The grant must be visible during the strobe cycle itself so the handshake completes on that edge.
  assign req_tready_o = grant;

  always_comb begin
    grant_word = '0;
    for (int k = 0; k < NREQ; k++)
      if (grant[k]) grant_word = grant_word | req_tdata_i[32*k +: 32];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge if_clk_i) begin
    if (if_rst_i) begin
      state          <= UNLOCKED;
      space_cnt      <= '0;
      good_cnt       <= '0;
      rr_ptr         <= '0;
      cout_command_o <= IDLE_VALUE;
      cout_train_o   <= 1'b0;
      locked_o       <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      space_cnt   <= frame_i ? '0 : space_cnt + 1'b1;
      unique case (state)
        UNLOCKED: begin
          if (frame_i) begin
            state    <= LOCKING;
            good_cnt <= '0;
          end
        end
        LOCKING: begin
          if (frame_good) begin
            if (good_cnt == 4'(LOCK_FRAMES - 1)) begin
              state    <= LOCKED;
              locked_o <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end else if (frame_bad) begin
            state <= UNLOCKED;
          end
        end
        LOCKED: begin
          if (frame_bad) begin
            state          <= UNLOCKED;
            locked_o       <= 1'b0;
            frame_err_o    <= 1'b1;
            cout_command_o <= IDLE_VALUE;
            cout_train_o   <= 1'b0;
          end else if (frame_good) begin
            cout_train_o <= train_i;
            if (|grant) begin
              cout_command_o <= grant_word;
              rr_ptr         <= next_ptr;
            end else begin
              cout_command_o <= IDLE_VALUE;
            end
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

`ifdef TURFIO_COUT_SCHED_STATS_EN
  logic [15:0] grant_cnt [NREQ];
  logic [15:0] idle_cnt;
  logic        idle_frame;

  assign idle_frame = (state == LOCKED) && frame_good && !train_i && !(|grant);

  // NOTE: a handful of flops, not a RAM, so the counter array is reset like any other register.
  always_ff @(posedge if_clk_i) begin
    if (if_rst_i || stat_clr_i) begin
      for (int k = 0; k < NREQ; k++) grant_cnt[k] <= '0;
      idle_cnt <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (grant[k] && (grant_cnt[k] != 16'hFFFF)) grant_cnt[k] <= grant_cnt[k] + 1'b1;
      if (idle_frame && (idle_cnt != 16'hFFFF)) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_comb begin
    stat_grants_o = '0;
    for (int k = 0; k < NREQ; k++) stat_grants_o[16*k +: 16] = grant_cnt[k];
  end
  assign stat_idle_o = idle_cnt;
`endif

endmodule

// File: tb/tb_turfio_cout_sched.sv
// Directed bench for turfio_cout_sched: lock, round-robin grants, training, spacing errors, reset.
module tb_turfio_cout_sched;

  localparam int NREQ = 3;

  logic                if_clk_i = 1'b0;
  logic                if_rst_i;
  logic                frame_i;
  logic [32*NREQ-1:0]  req_tdata_i;
  logic [NREQ-1:0]     req_tvalid_i;
  logic [NREQ-1:0]     req_tready_o;
  logic                train_i;
  logic [31:0]         cout_command_o;
  logic                cout_train_o;
  logic                locked_o;
  logic                frame_err_o;
`ifdef TURFIO_COUT_SCHED_STATS_EN
  logic                stat_clr_i;
  logic [16*NREQ-1:0]  stat_grants_o;
  logic [15:0]         stat_idle_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  turfio_cout_sched #(.NREQ(NREQ), .IDLE_VALUE(32'h0000_0000), .LOCK_FRAMES(4)) dut (
    .if_clk_i       (if_clk_i),
    .if_rst_i       (if_rst_i),
    .frame_i        (frame_i),
    .req_tdata_i    (req_tdata_i),
    .req_tvalid_i   (req_tvalid_i),
    .req_tready_o   (req_tready_o),
    .train_i        (train_i),
`ifdef TURFIO_COUT_SCHED_STATS_EN
    .stat_clr_i     (stat_clr_i),
    .stat_grants_o  (stat_grants_o),
    .stat_idle_o    (stat_idle_o),
`endif
    .cout_command_o (cout_command_o),
    .cout_train_o   (cout_train_o),
    .locked_o       (locked_o),
    .frame_err_o    (frame_err_o)
  );

  always #4 if_clk_i = ~if_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge if_clk_i);
    #1;
  endtask

  // One strobe followed by `gap` quiet cycles; checks grant, the registered update and its hold.
  task automatic do_frame(input logic [NREQ-1:0] exp_rdy, input logic [31:0] exp_cmd,
                          input logic exp_train, input int gap, input string tag);
    frame_i = 1'b1;
    #2;
    check({tag, ".rdy"}, 32'(req_tready_o), 32'(exp_rdy));
    tick();
    frame_i = 1'b0;
    check({tag, ".cmd"}, cout_command_o, exp_cmd);
    check({tag, ".trn"}, 32'(cout_train_o), 32'(exp_train));
    for (int i = 0; i < gap; i++) begin
      if (i == 2) check({tag, ".rdy_off"}, 32'(req_tready_o), 32'h0);
      tick();
    end
    check({tag, ".hold"}, cout_command_o, exp_cmd);
  endtask

  initial begin
    if_rst_i     = 1'b1;
    frame_i      = 1'b0;
    train_i      = 1'b0;
    req_tvalid_i = '0;
    req_tdata_i  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
`ifdef TURFIO_COUT_SCHED_STATS_EN
    stat_clr_i   = 1'b0;
`endif
    repeat (3) tick();
    check("rst.cmd",    cout_command_o, 32'h0);
    check("rst.trn",    32'(cout_train_o), 32'h0);
    check("rst.rdy",    32'(req_tready_o), 32'h0);
    check("rst.locked", 32'(locked_o), 32'h0);
    check("rst.err",    32'(frame_err_o), 32'h0);
    if_rst_i = 1'b0;

    // Lock: the initial strobe plus four good ones.
    for (int f = 0; f < 4; f++) do_frame(3'b000, 32'h0, 1'b0, 7, "lock");
    check("lock.pre", 32'(locked_o), 32'h0);
    do_frame(3'b000, 32'h0, 1'b0, 7, "lock5");
    check("lock.post", 32'(locked_o), 32'h1);

    // Requesters 0 and 2 alternate.
    req_tvalid_i = 3'b101;
    do_frame(3'b001, 32'h1111_1111, 1'b0, 7, "rr0a");
    do_frame(3'b100, 32'h3333_3333, 1'b0, 7, "rr2a");
    do_frame(3'b001, 32'h1111_1111, 1'b0, 7, "rr0b");
    do_frame(3'b100, 32'h3333_3333, 1'b0, 7, "rr2b");

    // Training blocks the grant; released at the next frame.
    req_tvalid_i = 3'b010;
    train_i      = 1'b1;
    do_frame(3'b000, 32'h0, 1'b1, 7, "train");
    train_i      = 1'b0;
    do_frame(3'b010, 32'h2222_2222, 1'b0, 7, "untrain");

    // No valid request: idle word, pointer stays at 2.
    req_tvalid_i = 3'b000;
    do_frame(3'b000, 32'h0, 1'b0, 7, "novalid");
    req_tvalid_i = 3'b111;
    do_frame(3'b100, 32'h3333_3333, 1'b0, 5, "ptrkeep");

    // Early strobe six cycles after the previous one.
    frame_i = 1'b1;
    #2;
    check("early.rdy", 32'(req_tready_o), 32'h0);
    tick();
    frame_i = 1'b0;
    check("early.err",    32'(frame_err_o), 32'h1);
    check("early.locked", 32'(locked_o), 32'h0);
    check("early.cmd",    cout_command_o, 32'h0);
    tick();
    check("early.err_off", 32'(frame_err_o), 32'h0);
    repeat (6) tick();
    for (int f = 0; f < 5; f++) do_frame(3'b000, 32'h0, 1'b0, 7, "relock1");
    check("relock1.locked", 32'(locked_o), 32'h1);

    // Suppressed strobe; pointer is 0 so requester 0 wins first.
    req_tvalid_i = 3'b001;
    do_frame(3'b001, 32'h1111_1111, 1'b0, 7, "premiss");
    check("miss.err_pre", 32'(frame_err_o), 32'h0);
    tick();
    check("miss.err",    32'(frame_err_o), 32'h1);
    check("miss.locked", 32'(locked_o), 32'h0);
    check("miss.cmd",    cout_command_o, 32'h0);
    tick();
    check("miss.err_off", 32'(frame_err_o), 32'h0);
    repeat (6) tick();
    for (int f = 0; f < 5; f++) do_frame(3'b000, 32'h0, 1'b0, 7, "relock2");
    check("relock2.locked", 32'(locked_o), 32'h1);
    do_frame(3'b001, 32'h1111_1111, 1'b0, 3, "postlock");

    // Reset mid-frame with a coincident strobe: the strobe must not count.
    if_rst_i = 1'b1;
    frame_i  = 1'b1;
    #2;
    check("rstmid.rdy", 32'(req_tready_o), 32'h0);
    tick();
    if_rst_i = 1'b0;
    frame_i  = 1'b0;
    check("rstmid.cmd",    cout_command_o, 32'h0);
    check("rstmid.locked", 32'(locked_o), 32'h0);
    repeat (7) tick();
    for (int f = 0; f < 4; f++) do_frame(3'b000, 32'h0, 1'b0, 7, "relock3");
    check("relock3.pre", 32'(locked_o), 32'h0);
`ifdef TURFIO_COUT_SCHED_STATS_EN
    stat_clr_i = 1'b1;
`endif
    do_frame(3'b000, 32'h0, 1'b0, 7, "relock3_5");
`ifdef TURFIO_COUT_SCHED_STATS_EN
    stat_clr_i = 1'b0;
`endif
    check("relock3.post", 32'(locked_o), 32'h1);

`ifdef TURFIO_COUT_SCHED_STATS_EN
    for (int f = 0; f < 3; f++) do_frame(3'b001, 32'h1111_1111, 1'b0, 7, "stat_g");
    req_tvalid_i = 3'b000;
    for (int f = 0; f < 2; f++) do_frame(3'b000, 32'h0, 1'b0, 7, "stat_i");
    check("stat.grants0", 32'(stat_grants_o[15:0]), 32'd3);
    check("stat.grants2", 32'(stat_grants_o[47:32]), 32'd0);
    check("stat.idle",    32'(stat_idle_o), 32'd2);
    req_tvalid_i = 3'b001;
    stat_clr_i   = 1'b1;
    frame_i      = 1'b1;
    #2;
    check("statclr.rdy", 32'(req_tready_o), 32'h1);
    tick();
    frame_i    = 1'b0;
    stat_clr_i = 1'b0;
    check("statclr.grants0", 32'(stat_grants_o[15:0]), 32'd0);
    check("statclr.idle",    32'(stat_idle_o), 32'd0);
    repeat (7) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
